// File: rtl/activation_skew_feeder.sv
// Activation feeder: issues per-lane im2col reads to the activation buffer, masks and
// diagonally skews the returned bytes onto the array's left edge, and tracks tile beats.
module activation_skew_feeder #(
    parameter int LANES   = 16,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int K_DEPTH = 147,
    parameter int CNT_W   = $clog2(K_DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_enable,
    input  logic                     io_clear,
    input  logic [LANES*ADDR_W-1:0]  io_rdAddr,
    input  logic [LANES-1:0]         io_addrValid,
    output logic [LANES-1:0]         mem_rdEn,
    output logic [LANES*ADDR_W-1:0]  mem_rdAddr,
    input  logic [LANES*DATA_W-1:0]  mem_rdData,
    output logic [LANES*DATA_W-1:0]  act_out,
    output logic [LANES-1:0]         act_valid,
    output logic                     tile_done,
    output logic                     busy,
    output logic [CNT_W-1:0]         beat_cnt
);

    logic             beat_fire;
    logic             last_beat;
    logic [LANES-1:0] issue_vld_q, issue_vld_d;
    logic [LANES-1:0] tag_q, tag_d;
    logic [LANES-1:0] lane_busy;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // NOTE: reset gates the read strobes combinationally so no read escapes while the flops are held.
    assign beat_fire  = reset & io_enable & ~io_clear;
    assign mem_rdEn   = {LANES{beat_fire}} & io_addrValid;
    assign mem_rdAddr = io_rdAddr;
    assign last_beat  = beat_fire && (beat_cnt_q == CNT_W'(K_DEPTH - 1));

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        issue_vld_d = mem_rdEn;
        beat_cnt_d  = beat_cnt_q;
        tag_d       = {tag_q[LANES-2:0], last_beat};
        if (io_clear) begin
            beat_cnt_d = '0;
            tag_d      = '0;
        end else if (beat_fire) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_vld_q <= '0;
            tag_q       <= '0;
            beat_cnt_q  <= '0;
        end else begin
            issue_vld_q <= issue_vld_d;
            tag_q       <= tag_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        // The buffer's output register is the capture stage; only the lane valid is held here.
        logic [DATA_W-1:0] cap_dat;
        assign cap_dat = issue_vld_q[g] ? mem_rdData[g*DATA_W +: DATA_W] : '0;

        if (g == 0) begin : g_direct
            assign act_out[0 +: DATA_W] = cap_dat;
            assign act_valid[0]         = issue_vld_q[0];
            assign lane_busy[0]         = 1'b0;
        end else begin : g_skew
            localparam int SW = g * DATA_W;
            localparam int VW = g;
            logic [SW-1:0] sk_dat_q, sk_dat_d;
            logic [VW-1:0] sk_vld_q, sk_vld_d;

            always_comb begin
                sk_dat_d = (sk_dat_q << DATA_W) | SW'(cap_dat);
                sk_vld_d = (sk_vld_q << 1) | VW'(issue_vld_q[g]);
                if (io_clear) begin
                    sk_dat_d = '0;
                    sk_vld_d = '0;
                end
            end

            // NOTE: skew data is reset too, so an idle row never shows a stale byte.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sk_dat_q <= '0;
                    sk_vld_q <= '0;
                end else begin
                    sk_dat_q <= sk_dat_d;
                    sk_vld_q <= sk_vld_d;
                end
            end

            assign act_out[g*DATA_W +: DATA_W] = sk_dat_q[SW-1 -: DATA_W];
            assign act_valid[g]                = sk_vld_q[VW-1];
            assign lane_busy[g]                = |sk_vld_q;
        end
    end

    assign busy      = |{issue_vld_q, lane_busy, tag_q};
    assign tile_done = tag_q[LANES-1];
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_activation_skew_feeder.sv
// Bench for activation_skew_feeder: directed scenarios plus a randomized run checked
// against a history-based model (per-cycle issue log, flush log, lane delay = lane index + 1).
module tb_activation_skew_feeder;
    localparam int LANES   = 16;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 8;
    localparam int K_DEPTH = 147;
    localparam int CNT_W   = $clog2(K_DEPTH);
    localparam int MAXC    = 4096;

    logic                    clock, reset, io_enable, io_clear;
    logic [LANES*ADDR_W-1:0] io_rdAddr, mem_rdAddr;
    logic [LANES-1:0]        io_addrValid, mem_rdEn, act_valid;
    logic [LANES*DATA_W-1:0] mem_rdData, act_out;
    logic                    tile_done, busy;
    logic [CNT_W-1:0]        beat_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = -1;
    int m_cnt  = 0;
    bit [7:0] key = 8'h00;

    bit [LANES-1:0]  m_iss [MAXC];
    bit [DATA_W-1:0] m_dat [MAXC][LANES];
    bit              m_tag [MAXC];
    bit              m_clr [MAXC];
    bit              m_rst [MAXC];
    int              m_cnt_at [MAXC];

    activation_skew_feeder dut (
        .clock(clock), .reset(reset), .io_enable(io_enable), .io_clear(io_clear),
        .io_rdAddr(io_rdAddr), .io_addrValid(io_addrValid),
        .mem_rdEn(mem_rdEn), .mem_rdAddr(mem_rdAddr), .mem_rdData(mem_rdData),
        .act_out(act_out), .act_valid(act_valid), .tile_done(tile_done),
        .busy(busy), .beat_cnt(beat_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit [DATA_W-1:0] mem_byte(int lane, bit [ADDR_W-1:0] a);
        return 8'(a[7:0] + 8'h10) ^ 8'(a[ADDR_W-1:8] * key) ^ 8'(lane * key);
    endfunction

    // Buffer model: one-cycle read latency; unread lanes return garbage to expose missing masking.
    always @(posedge clock) begin
        for (int i = 0; i < LANES; i++)
            mem_rdData[i*DATA_W +: DATA_W] <= mem_rdEn[i] ?
                mem_byte(i, mem_rdAddr[i*ADDR_W +: ADDR_W]) : 8'($urandom);
    end

    function automatic bit [LANES*ADDR_W-1:0] rand_addr();
        bit [LANES*ADDR_W-1:0] a;
        for (int i = 0; i < LANES; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        return a;
    endfunction

    // An element issued at t survives to cycle c unless cleared in (t, c) or reset in (t, c].
    function automatic bit alive(int t, int c);
        for (int k = t + 1; k <= c; k++) begin
            if (m_rst[k]) return 1'b0;
            if (k < c && m_clr[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit [LANES-1:0] exp_av(int c);
        bit [LANES-1:0] v = '0;
        for (int i = 0; i < LANES; i++) begin
            int t = c - 1 - i;
            if (t >= 0 && m_iss[t][i] && alive(t, c)) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic bit [LANES*DATA_W-1:0] exp_ao(int c);
        bit [LANES*DATA_W-1:0] o = '0;
        for (int i = 0; i < LANES; i++) begin
            int t = c - 1 - i;
            if (t >= 0 && m_iss[t][i] && alive(t, c)) o[i*DATA_W +: DATA_W] = m_dat[t][i];
        end
        return o;
    endfunction

    function automatic bit exp_done(int c);
        int t = c - LANES;
        return (t >= 0) && m_tag[t] && alive(t, c);
    endfunction

    function automatic bit exp_busy(int c);
        for (int t = c - LANES; t < c; t++) begin
            if (t >= 0 && alive(t, c)) begin
                if (m_tag[t]) return 1'b1;
                for (int j = 0; j < LANES; j++)
                    if (m_iss[t][j] && c <= t + 1 + j) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Advance one cycle: drive inputs just after the edge, log them, return at the negedge.
    task automatic step(input bit rst_n, input bit en, input bit clr,
                        input bit [LANES-1:0] vld, input bit [LANES*ADDR_W-1:0] addr);
        @(posedge clock);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            errors++;
            $display("FAIL cycle_budget: reached %0d cycles, limit %0d", cyc, MAXC);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "cycle budget exhausted");
        end
        reset = rst_n; io_enable = en; io_clear = clr; io_addrValid = vld; io_rdAddr = addr;
        m_rst[cyc] = !rst_n;
        m_clr[cyc] = rst_n && clr;
        if (!rst_n) m_cnt = 0;
        m_cnt_at[cyc] = m_cnt;
        if (rst_n && en && !clr) begin
            m_iss[cyc] = vld;
            for (int i = 0; i < LANES; i++)
                m_dat[cyc][i] = vld[i] ? mem_byte(i, addr[i*ADDR_W +: ADDR_W]) : '0;
            if (m_cnt == K_DEPTH - 1) begin
                m_tag[cyc] = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else if (rst_n && clr) begin
            m_cnt = 0;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        bit [LANES*ADDR_W-1:0] a;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, '1, rand_addr());
            checks++;
            if (mem_rdEn !== '0) begin errors++; $display("FAIL reset_rden: got %h expected 0", mem_rdEn); end
            checks++;
            if (act_valid !== '0) begin errors++; $display("FAIL reset_act_valid: got %h expected 0", act_valid); end
            checks++;
            if (busy !== 1'b0 || tile_done !== 1'b0 || beat_cnt !== '0 || act_out !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got busy=%b done=%b cnt=%0d act=%h expected all 0",
                         busy, tile_done, beat_cnt, act_out);
            end
        end
        step(1'b1, 1'b0, 1'b0, '0, '0);
        a = rand_addr();
        step(1'b1, 1'b1, 1'b0, '1, a);
        checks++;
        if (mem_rdEn !== 16'hFFFF) begin errors++; $display("FAIL first_issue_rden: got %h expected ffff", mem_rdEn); end
        checks++;
        if (mem_rdAddr !== a) begin errors++; $display("FAIL first_issue_addr: got %h expected %h", mem_rdAddr, a); end
        step(1'b1, 1'b0, 1'b0, '0, '0);
        checks++;
        if (beat_cnt !== CNT_W'(1) || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_issue_count: got cnt=%0d busy=%b expected cnt=1 busy=1", beat_cnt, busy);
        end
        repeat (17) step(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_skew();
        bit [LANES*ADDR_W-1:0] a;
        bit [LANES-1:0]        ev;
        bit [LANES*DATA_W-1:0] eo;
        key = 8'h00;
        for (int i = 0; i < LANES; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'(i);
        step(1'b1, 1'b0, 1'b1, '0, '0);
        step(1'b1, 1'b1, 1'b0, '1, a);
        for (int d = 1; d <= 17; d++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0);
            ev = '0;
            eo = '0;
            if (d - 1 < LANES) begin
                ev[d-1] = 1'b1;
                eo[(d-1)*DATA_W +: DATA_W] = 8'h10 + 8'(d - 1);
            end
            checks++;
            if (act_valid !== ev) begin errors++; $display("FAIL skew_valid d=%0d: got %h expected %h", d, act_valid, ev); end
            checks++;
            if (act_out !== eo) begin errors++; $display("FAIL skew_data d=%0d: got %h expected %h", d, act_out, eo); end
            checks++;
            if (busy !== (d <= LANES)) begin errors++; $display("FAIL skew_busy d=%0d: got %b expected %b", d, busy, d <= LANES); end
        end
    endtask

    task automatic test_invalid();
        bit [LANES*ADDR_W-1:0] a;
        bit [LANES-1:0]        ev;
        bit [LANES*DATA_W-1:0] eo;
        key = 8'h00;
        for (int i = 0; i < LANES; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'(i);
        step(1'b1, 1'b0, 1'b1, '0, '0);
        step(1'b1, 1'b1, 1'b0, 16'h00FF, a);
        checks++;
        if (mem_rdEn !== 16'h00FF) begin errors++; $display("FAIL invalid_rden: got %h expected 00ff", mem_rdEn); end
        for (int d = 1; d <= LANES; d++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0);
            ev = '0;
            eo = '0;
            if (d - 1 < 8) begin
                ev[d-1] = 1'b1;
                eo[(d-1)*DATA_W +: DATA_W] = 8'h10 + 8'(d - 1);
            end
            checks++;
            if (act_valid !== ev || act_out !== eo) begin
                errors++;
                $display("FAIL invalid_lanes d=%0d: got v=%h o=%h expected v=%h o=%h", d, act_valid, act_out, ev, eo);
            end
        end
    endtask

    task automatic test_tile();
        int pulses = 0;
        step(1'b1, 1'b0, 1'b1, '0, '0);
        for (int r = 0; r < 314; r++) begin
            step(1'b1, r < 2 * K_DEPTH, 1'b0, LANES'($urandom), rand_addr());
            if (tile_done === 1'b1) pulses++;
            checks++;
            if (tile_done !== (r == 162 || r == 309)) begin
                errors++;
                $display("FAIL tile_done r=%0d: got %b expected %b", r, tile_done, r == 162 || r == 309);
            end
            checks++;
            if (beat_cnt !== CNT_W'(((r < 2 * K_DEPTH) ? r : 2 * K_DEPTH) % K_DEPTH)) begin
                errors++;
                $display("FAIL tile_beat_cnt r=%0d: got %0d expected %0d", r, beat_cnt,
                         ((r < 2 * K_DEPTH) ? r : 2 * K_DEPTH) % K_DEPTH);
            end
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL tile_pulse_count: got %0d expected 2", pulses); end
    endtask

    task automatic test_pause();
        bit en;
        int exp_cnt;
        bit exp_v0;
        step(1'b1, 1'b0, 1'b1, '0, '0);
        for (int r = 0; r < 40; r++) begin
            en = (r < 16) || (r >= 18 && r < 24);
            step(1'b1, en, 1'b0, '1, rand_addr());
            exp_cnt = (r < 16) ? r : (r <= 18) ? 16 : ((r - 2 > 22) ? 22 : r - 2);
            exp_v0  = (r >= 1 && r <= 16) || (r >= 19 && r <= 24);
            checks++;
            if (beat_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL pause_cnt r=%0d: got %0d expected %0d", r, beat_cnt, exp_cnt); end
            checks++;
            if (act_valid[0] !== exp_v0 || tile_done !== 1'b0) begin
                errors++;
                $display("FAIL pause_lane0 r=%0d: got v0=%b done=%b expected v0=%b done=0", r, act_valid[0], tile_done, exp_v0);
            end
        end
    endtask

    task automatic test_clear();
        step(1'b1, 1'b0, 1'b1, '0, '0);
        for (int r = 0; r < 50; r++) step(1'b1, 1'b1, 1'b0, '1, rand_addr());
        step(1'b1, 1'b1, 1'b1, '1, rand_addr());
        checks++;
        if (mem_rdEn !== '0) begin errors++; $display("FAIL clear_rden: got %h expected 0", mem_rdEn); end
        checks++;
        if (beat_cnt !== CNT_W'(50)) begin errors++; $display("FAIL clear_cnt_before: got %0d expected 50", beat_cnt); end
        step(1'b1, 1'b0, 1'b0, '0, '0);
        checks++;
        if (beat_cnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_after: got cnt=%0d busy=%b expected cnt=0 busy=0", beat_cnt, busy);
        end
        for (int r = 0; r < 20; r++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0);
            checks++;
            if (act_valid !== '0 || tile_done !== 1'b0) begin
                errors++;
                $display("FAIL clear_drain r=%0d: got v=%h done=%b expected 0", r, act_valid, tile_done);
            end
        end
    endtask

    task automatic test_random();
        bit rst_n, en, clr;
        bit [LANES-1:0]        v;
        bit [LANES*ADDR_W-1:0] a;
        bit [LANES-1:0]        ev;
        bit [LANES*DATA_W-1:0] eo;
        key = 8'($urandom_range(1, 255));
        for (int n = 0; n < 720; n++) begin
            rst_n = !(n == 350 || n == 351);
            en    = (n < 700) && ($urandom_range(0, 9) < 7);
            clr   = ($urandom_range(0, 499) == 0);
            v     = ($urandom_range(0, 3) == 0) ? '1 : LANES'($urandom);
            a     = rand_addr();
            step(rst_n, en, clr, v, a);
            ev = exp_av(cyc);
            eo = exp_ao(cyc);
            checks++;
            if (mem_rdEn !== m_iss[cyc]) begin errors++; $display("FAIL rand_rden c=%0d: got %h expected %h", cyc, mem_rdEn, m_iss[cyc]); end
            checks++;
            if (mem_rdAddr !== a) begin errors++; $display("FAIL rand_addr c=%0d: got %h expected %h", cyc, mem_rdAddr, a); end
            checks++;
            if (act_valid !== ev) begin errors++; $display("FAIL rand_valid c=%0d: got %h expected %h", cyc, act_valid, ev); end
            checks++;
            if (act_out !== eo) begin errors++; $display("FAIL rand_data c=%0d: got %h expected %h", cyc, act_out, eo); end
            checks++;
            if (tile_done !== exp_done(cyc)) begin errors++; $display("FAIL rand_done c=%0d: got %b expected %b", cyc, tile_done, exp_done(cyc)); end
            checks++;
            if (busy !== exp_busy(cyc)) begin errors++; $display("FAIL rand_busy c=%0d: got %b expected %b", cyc, busy, exp_busy(cyc)); end
            checks++;
            if (beat_cnt !== CNT_W'(m_cnt_at[cyc])) begin
                errors++;
                $display("FAIL rand_cnt c=%0d: got %0d expected %0d", cyc, beat_cnt, m_cnt_at[cyc]);
            end
        end
    endtask

    initial begin
        reset = 1'b0; io_enable = 1'b0; io_clear = 1'b0; io_addrValid = '0; io_rdAddr = '0;
        test_reset();
        test_skew();
        test_invalid();
        test_tile();
        test_pause();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
